// File: rtl/seq_detect_param_pkg.sv
// Shared constants for the parametrised serial sequence detector.
// Holds the detection modes and the default pattern and counter sizes.
package seq_detect_param_pkg;

  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } mode_e;

  localparam int             DEF_PAT_W   = 4;
  localparam logic [3:0]     DEF_PATTERN = 4'b0011;
  localparam int             DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial data, control and status bundle between a front-end and the detector.
// Single-cycle strobes, no flow control: every enabled bit is consumed.
interface seq_detect_param_if
  import seq_detect_param_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             en;
  logic             a;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             e;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, a, overlap, pat_load, pat_in,
    input  e, match_cnt, cnt_sat
  );

  modport slave (
    input  en, a, overlap, pat_load, pat_in,
    output e, match_cnt, cnt_sat
  );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with a registered all-ones flag; one cycle from inc to q.
// Never wraps: increments at the maximum are dropped, sat rises with the final step.
module sat_counter
  import seq_detect_param_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (inc && !sat) begin
      q   <= q + 1'b1;
      sat <= (q == MAX - 1'b1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with run-time pattern load; e pulses one cycle after the final bit.
// No backpressure: bits are consumed on every enabled edge; a pattern load discards a coincident bit.
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input logic               clk,
  input logic               clr,
  seq_detect_param_if.slave bus
);

  localparam int              SEEN_W   = $clog2(PAT_W + 1);
  localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W);
  localparam logic [SEEN_W-1:0] SEEN_ARM = SEEN_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  next_hist;
  logic [SEEN_W-1:0] seen;
  logic              accept;
  logic              hit;
  logic              e_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_sat_q;

  assign accept    = bus.en && !bus.pat_load;
  assign next_hist = {history[PAT_W-2:0], bus.a};
  // seen >= PAT_W-1 means this bit completes a window of fresh bits
  assign hit       = accept && (next_hist == pattern) && (seen >= SEEN_ARM);

  always_ff @(posedge clk) begin
    if (clr) begin
      pattern <= PATTERN;
      history <= '0;
      seen    <= '0;
      e_q     <= 1'b0;
    end else begin
      e_q <= hit;
      if (bus.pat_load) begin
        pattern <= bus.pat_in;
        history <= '0;
        seen    <= '0;
      end else if (bus.en) begin
        history <= next_hist;
        if (hit) begin
          seen <= (mode_e'(bus.overlap) == MODE_OVERLAP) ? SEEN_MAX : '0;
        end else if (seen != SEEN_MAX) begin
          seen <= seen + 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .clr (clr),
    .inc (hit),
    .q   (cnt_q),
    .sat (cnt_sat_q)
  );

  assign bus.e         = e_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = cnt_sat_q;

endmodule
